// File: rtl/ft600_pkg.sv
// Shared types and widths for the FT600 transmit-side arbitration logic.
package ft600_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      GAP
   } state_t;

   localparam int FT600_DATA_W = 16;
   localparam int FT600_BE_W   = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: the first set bit of valid at or above ptr,
// wrapping modulo N_REQ.
module rr_priority_picker #(
   parameter int N_REQ = 2,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   logic [IW-1:0] cand;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IW'((int'(ptr) + k) % N_REQ);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ft600_tx_arbiter.sv
// Round-robin burst arbiter sharing the FT600 transmit path between N_REQ streams,
// with a programmable idle gap between bursts so WR_N/TXE_N can re-arm.
module ft600_tx_arbiter
   import ft600_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int BURST_LEN  = 256,
   parameter int GAP_CYCLES = 2,
   parameter int DATA_WIDTH = FT600_DATA_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req_valid,
   input  logic [N_REQ-1:0]                 req_last,
   input  logic [N_REQ*DATA_WIDTH-1:0]      req_data,
   input  logic [N_REQ*FT600_BE_W-1:0]      req_be,
   output logic [N_REQ-1:0]                 req_ready,
   output logic                             tx_valid,
   output logic [DATA_WIDTH-1:0]            tx_data,
   output logic [FT600_BE_W-1:0]            tx_be,
   input  logic                             tx_ready,
   output logic [$clog2(N_REQ)-1:0]         grant_id,
   output logic                             burst_active,
   output logic [$clog2(BURST_LEN):0]       beat_cnt
);

   localparam int IW       = $clog2(N_REQ);
   localparam int CW       = $clog2(BURST_LEN) + 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [3:0]    gap_cnt;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          xfer;
   logic          at_limit;
   logic          burst_end;
   logic [IW-1:0] next_ptr;

   rr_priority_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Data path is a pure mux from the granted requester; nothing is buffered.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_be     = '0;
      req_ready = '0;
      if (state == BURST) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IW'(i)) begin
               tx_valid     = req_valid[i];
               tx_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
               tx_be        = req_be[i*FT600_BE_W +: FT600_BE_W];
               req_ready[i] = tx_ready;
            end
         end
      end
   end

   assign xfer         = tx_valid & tx_ready;
   assign at_limit     = (beat_cnt == CW'(BURST_LEN - 1));
   // Limit and req_last on the same beat collapse into one end condition.
   assign burst_end    = !req_valid[grant_id] | (xfer & (at_limit | req_last[grant_id]));
   assign next_ptr     = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign burst_active = (state == BURST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (xfer) beat_cnt <= beat_cnt + 1'b1;
               if (burst_end) begin
                  rr_ptr  <= next_ptr;
                  gap_cnt <= '0;
                  if (GAP_CYCLES == 0) begin
                     state    <= IDLE;
                     grant_id <= '0;
                     beat_cnt <= '0;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == 4'(GAP_LAST)) begin
                  state    <= IDLE;
                  grant_id <= '0;
                  beat_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, checked every
// cycle against a cycle-level behavioural model plus a per-source ordering scoreboard.
module tb_ft600_tx_arbiter;

   localparam int N   = 3;
   localparam int BL  = 16;
   localparam int GAP = 2;
   localparam int DW  = 16;
   localparam int IW  = 2;
   localparam int CW  = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*DW-1:0] req_data;
   logic [N*2-1:0]  req_be;
   logic            tx_valid, tx_ready;
   logic [DW-1:0]   tx_data;
   logic [1:0]      tx_be;
   logic [IW-1:0]   grant_id;
   logic            burst_active;
   logic [CW-1:0]   beat_cnt;

   always #5 clk = ~clk;

   ft600_tx_arbiter #(
      .N_REQ      (N),
      .BURST_LEN  (BL),
      .GAP_CYCLES (GAP),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_be       (req_be),
      .req_ready    (req_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_be        (tx_be),
      .tx_ready     (tx_ready),
      .grant_id     (grant_id),
      .burst_active (burst_active),
      .beat_cnt     (beat_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   // model: which requester owns the path, how many beats it has sent, gap cycles left
   bit m_known = 0;
   bit m_burst = 0;
   int m_gap   = 0;
   int m_gid   = 0;
   int m_beats = 0;
   int m_ptr   = 0;
   int seq[N];      // next beat number each source will present
   int rx_next[N];  // next beat number expected out of tx for each source

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] src_data(input int i);
      return {4'(i), 12'(seq[i])};
   endfunction

   function automatic logic [1:0] src_be(input int i);
      return 2'(seq[i] * 3 + i);
   endfunction

   task automatic drive(input int ph, input int c);
      logic [N-1:0] v, l;
      logic r, rs;
      v = '0; l = '0; r = 1'b1; rs = 1'b0;
      case (ph)
         1: rs = 1'b1;
         2: v[0] = 1'b1;
         3: v = 3'b011;
         4: begin v[1] = 1'b1; v[0] = (c >= 2); l[1] = (c == 3); end
         5: begin v[2] = 1'b1; r = (c % 2 == 1); end
         6: begin v[0] = (c <= 5) || (c >= 12); v[1] = 1'b1; end
         7: begin v[1] = 1'b1; v[0] = (c >= 11); rs = (c == 10); end
         default: begin
            for (int i = 0; i < N; i++) begin
               v[i] = ($urandom_range(0, 99) < 70);
               l[i] = ($urandom_range(0, 99) < 10);
            end
            r  = ($urandom_range(0, 99) < 75);
            rs = ($urandom_range(0, 299) == 0);
         end
      endcase
      if (c < 0) begin
         rs = 1'b1;
         v  = '0;
         l  = '0;
      end
      rst       = rs;
      req_valid = v;
      req_last  = l;
      tx_ready  = r;
      for (int i = 0; i < N; i++) begin
         req_data[i*DW +: DW] = src_data(i);
         req_be[i*2 +: 2]     = src_be(i);
      end
   endtask

   task automatic compare(input int ph, input int c);
      logic          e_tv;
      logic [DW-1:0] e_data;
      logic [1:0]    e_be;
      logic [N-1:0]  e_rdy;
      int            src;
      if (!m_known) return;
      e_tv   = m_burst && req_valid[m_gid];
      e_data = m_burst ? src_data(m_gid) : '0;
      e_be   = m_burst ? src_be(m_gid) : '0;
      e_rdy  = (m_burst && tx_ready) ? N'(1 << m_gid) : '0;
      check("tx_valid", 32'(tx_valid), 32'(e_tv));
      check("tx_data", 32'(tx_data), 32'(e_data));
      check("tx_be", 32'(tx_be), 32'(e_be));
      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("burst_active", 32'(burst_active), 32'(m_burst));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("beat_cnt", 32'(beat_cnt), 32'(m_beats));
      // independent ordering check on beats actually handed to the FT600 side
      if (tx_valid === 1'b1 && tx_ready) begin
         src = int'(tx_data[15:12]);
         if (src < N) begin
            check("beat_order", 32'(tx_data[11:0]), 32'(12'(rx_next[src])));
            rx_next[src] = int'(tx_data[11:0]) + 1;
         end else begin
            check("beat_src", 32'(src), 32'(m_gid));
         end
      end
      // hand-computed expectations for the directed scenarios
      case (ph)
         2: begin
            if (c == 1)  check("p2_first_beat", 32'(tx_data), 32'h0000);
            if (c == 17) check("p2_cnt_full", 32'(beat_cnt), 32'd16);
            if (c == 17) check("p2_gap_inactive", 32'(burst_active), 32'd0);
            if (c == 19) check("p2_arb_cycle", 32'(tx_valid), 32'd0);
            if (c == 20) check("p2_second_burst", 32'(tx_data), 32'h0010);
         end
         3: begin
            if (c == 5)  check("p3_grant0", 32'(grant_id), 32'd0);
            if (c == 25) check("p3_grant1", 32'(grant_id), 32'd1);
            if (c == 45) check("p3_grant0_again", 32'(grant_id), 32'd0);
         end
         4: begin
            if (c == 4) check("p4_last_cnt", 32'(beat_cnt), 32'd3);
            if (c == 7) check("p4_next_grant", 32'(grant_id), 32'd0);
            if (c == 7) check("p4_next_active", 32'(burst_active), 32'd1);
         end
         5: begin
            if (c == 2) check("p5_hold_data", 32'(tx_data), 32'h2001);
            if (c == 3) check("p5_cnt_hold", 32'(beat_cnt), 32'd1);
            if (c == 4) check("p5_cnt_inc", 32'(beat_cnt), 32'd2);
         end
         6: begin
            if (c == 10) check("p6_other_grant", 32'(grant_id), 32'd1);
            if (c == 29) check("p6_reserved", 32'(grant_id), 32'd0);
         end
         7: begin
            if (c == 11) check("p7_rst_valid", 32'(tx_valid), 32'd0);
            if (c == 11) check("p7_rst_active", 32'(burst_active), 32'd0);
            if (c == 11) check("p7_rst_grant", 32'(grant_id), 32'd0);
            if (c == 12) check("p7_restart_grant", 32'(grant_id), 32'd0);
         end
         default: ;
      endcase
   endtask

   task automatic model_step();
      bit xfer;
      bit picked;
      xfer = m_known && m_burst && req_valid[m_gid] && tx_ready;
      if (xfer) seq[m_gid]++;
      if (rst) begin
         m_known = 1;
         m_burst = 0;
         m_gap   = 0;
         m_gid   = 0;
         m_beats = 0;
         m_ptr   = 0;
      end else if (!m_known) begin
         return;
      end else if (m_burst) begin
         if (xfer) m_beats++;
         if (!req_valid[m_gid] || (xfer && (m_beats == BL || req_last[m_gid]))) begin
            m_ptr   = (m_gid + 1) % N;
            m_burst = 0;
            m_gap   = GAP;
            if (GAP == 0) begin
               m_gid   = 0;
               m_beats = 0;
            end
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin
            m_gid   = 0;
            m_beats = 0;
         end
      end else begin
         picked = 0;
         for (int k = 0; k < N; k++) begin
            if (!picked && req_valid[(m_ptr + k) % N]) begin
               picked  = 1;
               m_burst = 1;
               m_gid   = (m_ptr + k) % N;
               m_beats = 0;
            end
         end
      end
   endtask

   task automatic run_phase(input int ph, input int len);
      for (int c = -1; c < len; c++) begin
         @(posedge clk);
         #1;
         drive(ph, c);
         @(negedge clk);
         compare(ph, c);
         model_step();
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      req_be    = '0;
      tx_ready  = 1'b0;
      for (int i = 0; i < N; i++) begin
         seq[i]     = 0;
         rx_next[i] = 0;
      end
      run_phase(1, 2);
      run_phase(2, 40);
      run_phase(3, 60);
      run_phase(4, 12);
      run_phase(5, 20);
      run_phase(6, 35);
      run_phase(7, 20);
      run_phase(8, 2000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
